// File: rtl/mul_cmp_pkg.sv
// Shared sizing, column geometry helpers and FSM state type for the
// multiplier column-compressor sequencer.
package mul_cmp_pkg;

    localparam int unsigned W    = 23;
    localparam int unsigned COLS = 2 * W - 1;
    localparam int unsigned PW   = 2 * W + 1;
    localparam int unsigned TW   = $clog2(W);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StWait,
        StResp
    } state_e;

    // Number of partial-product bits landing in column k.
    function automatic int unsigned col_height(input int unsigned k);
        return ((k + 1) < (COLS - k)) ? (k + 1) : (COLS - k);
    endfunction

    // Lowest a-operand index contributing to column k.
    function automatic int unsigned col_base(input int unsigned k);
        return (k >= W) ? (k - W + 1) : 0;
    endfunction

endpackage

// File: rtl/pp_column_gen.sv
// Combinational partial-product serialiser: for shift step t, produce one bit
// per compressor column so that each column receives its h bits in the last
// h shift cycles.
module pp_column_gen
    import mul_cmp_pkg::*;
(
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    input  logic [TW-1:0]   t_i,
    input  logic            en_i,
    output logic [COLS-1:0] src_bit_o
);

    for (genvar k = 0; k < COLS; k++) begin : g_col
        localparam int unsigned H    = col_height(k);
        localparam int unsigned Base = col_base(k);

        // Partial products of this column, zero-padded to W entries so the
        // t-derived index always has a full-width select.
        logic [W-1:0] pp;

        for (genvar j = 0; j < W; j++) begin : g_pp
            if (j < H) begin : g_bit
                assign pp[j] = a_i[Base + j] & b_i[k - Base - j];
            end else begin : g_pad
                assign pp[j] = 1'b0;
            end
        end

        if (H == W) begin : g_full
            // Tallest column emits on every shift step.
            assign src_bit_o[k] = en_i & pp[t_i];
        end else begin : g_short
            localparam logic [TW-1:0] Off = TW'(W - H);
            logic [TW-1:0] m;
            assign m = t_i - Off;
            // Leading zeros first so older bits fall out of the h-deep register.
            assign src_bit_o[k] = (en_i && (t_i >= Off)) ? pp[m] : 1'b0;
        end
    end

endmodule

// File: rtl/mul_compressor_sequencer.sv
// Drives one W x W multiplication through the column-compressor harness,
// samples the compressor result in its single valid cycle and checks it
// against a behavioural product. Keeps saturating pass/error counters.
module mul_compressor_sequencer
    import mul_cmp_pkg::*;
#(
    parameter int unsigned LAT    = 0,
    parameter logic [15:0] CntSat = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [COLS-1:0] src_bit,
    input  logic [PW-1:0]   dst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PW-1:0]   product,
    output logic            err,
    output logic [15:0]     pass_cnt,
    output logic [15:0]     err_cnt
);

    localparam int unsigned        WaitW    = $clog2(LAT + 2);
    localparam logic [TW-1:0]      TLast    = TW'(W - 1);
    localparam logic [WaitW-1:0]   WaitLast = WaitW'(LAT);

    state_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [PW-1:0]     product_q, product_d;
    logic              err_q, err_d;
    logic [15:0]       pass_q, pass_d;
    logic [15:0]       errc_q, errc_d;

    logic [2*W-1:0]    ref_prod;
    logic              mismatch;
    logic              shift_en;

    assign ref_prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    assign mismatch = (dst != {1'b0, ref_prod});
    assign shift_en = (state_q == StShift);

    pp_column_gen u_pp_column_gen (
        .a_i       (a_q),
        .b_i       (b_q),
        .t_i       (t_q),
        .en_i      (shift_en),
        .src_bit_o (src_bit)
    );

    // State, operand latches, sampled result and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            t_q       <= '0;
            wait_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
            pass_q    <= '0;
            errc_q    <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            wait_q    <= wait_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            errc_q    <= errc_d;
        end
    end

    // Next-state: accept, serialise W steps, wait out the compressor, respond.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        wait_d    = wait_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        err_d     = err_q;
        pass_d    = pass_q;
        errc_d    = errc_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    t_d     = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (t_q == TLast) begin
                    wait_d  = '0;
                    state_d = StWait;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StWait: begin
                // dst is only meaningful in this one cycle; zeros follow.
                if (wait_q == WaitLast) begin
                    product_d = dst;
                    err_d     = mismatch;
                    state_d   = StResp;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                    if (err_q) begin
                        if (errc_q != CntSat) errc_d = errc_q + 1'b1;
                    end else begin
                        if (pass_q != CntSat) pass_d = pass_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StResp);
    assign product   = product_q;
    assign err       = err_q;
    assign pass_cnt  = pass_q;
    assign err_cnt   = errc_q;

endmodule

// File: tb/tb_mul_compressor_sequencer.sv
// Self-checking bench: models the shift-register harness plus an ideal
// compressor, checks src_bit per step, latency, back-pressure, reset abort and
// counter behaviour through a response scoreboard.
`timescale 1ns/1ps
module tb_mul_compressor_sequencer;
    import mul_cmp_pkg::*;

    localparam int unsigned LAT      = 0;
    localparam logic [15:0] SatSmall = 16'd4;
    localparam int          WI       = W;
    localparam int          CI       = COLS;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            out_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            fault;
    logic [PW-1:0]   dst;
    logic [PW-1:0]   dst_model;

    logic            in_ready, out_valid, err;
    logic [COLS-1:0] src_bit;
    logic [PW-1:0]   product;
    logic [15:0]     pass_cnt, err_cnt;

    logic            in_ready_s, out_valid_s, err_s;
    logic [COLS-1:0] src_bit_s;
    logic [PW-1:0]   product_s;
    logic [15:0]     pass_cnt_s, err_cnt_s;

    int errors = 0;
    int checks = 0;
    int n_pass = 0;
    int n_err  = 0;
    longint accept_time = 0;

    typedef struct packed {
        logic [PW-1:0] prod;
        logic          e;
    } resp_t;
    resp_t sb_q[$];

    always #5 clk = ~clk;

    mul_compressor_sequencer #(.LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .src_bit   (src_bit),
        .dst       (dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .err       (err),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt)
    );

    // Lockstep copy with a tiny saturation point so saturation is reachable.
    mul_compressor_sequencer #(.LAT(LAT), .CntSat(SatSmall)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .a         (a),
        .b         (b),
        .src_bit   (src_bit_s),
        .dst       (dst),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .product   (product_s),
        .err       (err_s),
        .pass_cnt  (pass_cnt_s),
        .err_cnt   (err_cnt_s)
    );

    function automatic int tb_h(input int k);
        return ((k + 1) < (CI - k)) ? (k + 1) : (CI - k);
    endfunction

    function automatic logic [W-1:0] hmask(input int k);
        logic [W:0] one;
        one = 1;
        return W'((one << tb_h(k)) - 1);
    endfunction

    function automatic logic [COLS-1:0] exp_src(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input int t);
        logic [COLS-1:0] v;
        v = '0;
        for (int k = 0; k < CI; k++) begin
            int h, base, m;
            h    = tb_h(k);
            base = (k > WI - 1) ? (k - WI + 1) : 0;
            m    = t - (WI - h);
            if (m >= 0) v[k] = x[base + m] & y[k - base - m];
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return {1'b0, p};
    endfunction

    // Harness model: h-deep shift register per column, shifting every clock.
    logic [W-1:0] col_q [COLS] = '{default: '0};
    always @(posedge clk) begin
        for (int k = 0; k < CI; k++) col_q[k] <= {col_q[k][W-2:0], src_bit[k]} & hmask(k);
    end

    // Ideal compressor: weighted sum of every bit present in the columns.
    always_comb begin
        dst_model = '0;
        for (int k = 0; k < CI; k++) dst_model = dst_model + (PW'($countones(col_q[k])) << k);
    end
    assign dst = dst_model ^ {{(PW - 1){1'b0}}, fault};

    task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic flt,
                            input logic [PW-1:0] exp_prod, input logic exp_e, input int hold);
        resp_t r;
        logic [PW-1:0] p0;
        logic e0;
        int cyc;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL op_in_ready: got %b want 1", in_ready);
        end
        a = x; b = y; fault = flt; in_valid = 1'b1;
        @(posedge clk);
        accept_time = $time;
        r.prod = exp_prod; r.e = exp_e;
        sb_q.push_back(r);
        #1;
        in_valid = 1'b0; a = '1; b = '1;
        for (int t = 0; t < WI; t++) begin
            @(negedge clk);
            checks++;
            if (src_bit !== exp_src(x, y, t)) begin
                errors++;
                $display("FAIL src_bit t=%0d: got %h want %h", t, src_bit, exp_src(x, y, t));
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL shift_flags t=%0d: out_valid=%b in_ready=%b want 0 0",
                         t, out_valid, in_ready);
            end
        end
        for (int i = 0; i <= int'(LAT); i++) begin
            @(negedge clk);
            checks++;
            if (src_bit !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_phase: src_bit=%h out_valid=%b want 0 0", src_bit, out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: out_valid=%b want 1 at %0d cycles", out_valid, WI + 1 + LAT);
        end
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout: out_valid=%b want 1", out_valid);
        end
        p0 = product; e0 = err;
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (out_valid !== 1'b1 || product !== p0 || err !== e0 || in_ready !== 1'b0 ||
                src_bit !== '0 || pass_cnt !== 16'(n_pass) || err_cnt !== 16'(n_err)) begin
                errors++;
                $display("FAIL backpressure i=%0d: ov=%b prod=%h err=%b rdy=%b src=%h pc=%0d ec=%0d want 1 %h %b 0 0 %0d %0d",
                         i, out_valid, product, err, in_ready, src_bit, pass_cnt, err_cnt,
                         p0, e0, n_pass, n_err);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            r = sb_q.pop_front();
            if (product !== r.prod || err !== r.e) begin
                errors++;
                $display("FAIL result: product=%h err=%b want %h %b", product, err, r.prod, r.e);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (exp_e) n_err++; else n_pass++;
        checks++;
        if (out_valid !== 1'b0 || pass_cnt !== 16'(n_pass) || err_cnt !== 16'(n_err)) begin
            errors++;
            $display("FAIL after_accept: ov=%b pc=%0d ec=%0d want 0 %0d %0d",
                     out_valid, pass_cnt, err_cnt, n_pass, n_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fault = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || src_bit !== '0 || product !== '0 ||
            err !== 1'b0 || pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b src=%h prod=%h err=%b pc=%0d ec=%0d want 1 0 0 0 0 0 0",
                     in_ready, out_valid, src_bit, product, err, pass_cnt, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        drive_op(23'd0, 23'd0, 1'b0, 47'd0, 1'b0, 0);
        checks++;
        if (pass_cnt !== 16'd1) begin
            errors++;
            $display("FAIL zero_pass_cnt: got %0d want 1", pass_cnt);
        end
    endtask

    task automatic test_max();
        drive_op(23'h7FFFFF, 23'h7FFFFF, 1'b0, 47'h3FFFFF000001, 1'b0, 0);
    endtask

    task automatic test_sparse();
        drive_op(23'd1, 23'h555555, 1'b0, 47'h555555, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        drive_op(23'h012345, 23'h006789, 1'b0, ref_mul(23'h012345, 23'h006789), 1'b0, 10);
    endtask

    task automatic test_back_to_back();
        longint prev;
        logic [W-1:0] x, y;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            drive_op(x, y, 1'b0, ref_mul(x, y), 1'b0, 0);
            if (i > 0) begin
                checks++;
                if (accept_time - prev != longint'((WI + 3 + LAT) * 10)) begin
                    errors++;
                    $display("FAIL issue_interval: got %0d ns want %0d ns",
                             accept_time - prev, (WI + 3 + LAT) * 10);
                end
            end
            prev = accept_time;
        end
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        a = 23'd9; b = 23'd11; fault = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || src_bit !== '0 || product !== '0 ||
            err !== 1'b0 || pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL abort_reset: rdy=%b ov=%b src=%h prod=%h err=%b pc=%0d ec=%0d want 1 0 0 0 0 0 0",
                     in_ready, out_valid, src_bit, product, err, pass_cnt, err_cnt);
        end
        sb_q.delete();
        n_pass = 0; n_err = 0;
        @(negedge clk);
        rst = 1'b0;
        drive_op(23'd3, 23'd5, 1'b0, 47'd15, 1'b0, 0);
    endtask

    task automatic test_fault();
        for (int i = 0; i < 6; i++) drive_op(23'd2, 23'd2, 1'b1, 47'd5, 1'b1, 0);
        fault = 1'b0;
        checks++;
        if (err_cnt !== 16'd6 || pass_cnt !== 16'd1) begin
            errors++;
            $display("FAIL fault_counts: ec=%0d pc=%0d want 6 1", err_cnt, pass_cnt);
        end
        checks++;
        if (err_cnt_s !== SatSmall || pass_cnt_s !== 16'd1) begin
            errors++;
            $display("FAIL saturation: ec=%0d pc=%0d want %0d 1", err_cnt_s, pass_cnt_s, SatSmall);
        end
        checks++;
        if ({in_ready_s, out_valid_s, err_s, product_s, src_bit_s} !==
            {in_ready, out_valid, err, product, src_bit}) begin
            errors++;
            $display("FAIL lockstep: sat=%b%b%b %h %h main=%b%b%b %h %h", in_ready_s, out_valid_s,
                     err_s, product_s, src_bit_s, in_ready, out_valid, err, product, src_bit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_fault();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_compressor_sequencer.md
# mul_compressor_sequencer

Sequences one unsigned W×W multiplication through the column-compressor test harness and checks the result. It accepts an operand pair over a valid/ready handshake and serialises the partial-product bits into the per-column shift registers, W bits per column over W cycles. It then samples the 2W+1-bit compressor output in its single valid cycle and compares it against a behavioural product. It sits between the bench/host side and the shift-register harness that wraps the compressor.

## Interface
- W, 23, operand width; harness has 2W-1 columns of height min(k+1, 2W-1-k)
- LAT, 0, compressor pipeline depth in clocks (0 = combinational)
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  high only in IDLE
- a, b  in  W each  unsigned operands
- src_bit  out  2W-1  serial bit per column; bit k drives harness input srcK_
- dst  in  2W+1  compressor result (dst0..dst2W concatenated, dst0 = LSB)
- out_valid  out  1  result held until accepted
- out_ready  in  1  result consumer ready
- product  out  2W+1  sampled dst
- err  out  1  product != {1'b0, a*b}
- pass_cnt, err_cnt  out  16 each  saturating run counters

## Operation
- States: IDLE → SHIFT → WAIT → RESP → IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a and b, clear t, and go to SHIFT.
- SHIFT lasts W cycles, t = 0..W-1, and drives column bits from the latched operands.
  - Column k: h=min(k+1,2W-1-k), base=max(0,k-W+1), m=t-(W-h).
  - If m≥0, src_bit[k] = a[base+m] & b[k-base-m]; otherwise 0.
  - Across the W cycles each column receives exactly its h partial-product bits last.
- Harness registers shift every clock unconditionally. src_bit is therefore 0 in every state except SHIFT.
- WAIT lasts LAT+1 cycles. At its final edge, dst is registered into product and err = (dst != {1'b0, a_lat*b_lat}).
- RESP: out_valid=1; product and err are held stable until out_valid&out_ready, then the block returns to IDLE.
- Counters update on that acceptance edge: err ? err_cnt++ : pass_cnt++. Both saturate at 16'hFFFF.
- in_valid is ignored outside IDLE. There is no overlap of operations.

## Timing
- Reset (asynchronous, any state): state=IDLE, t=0, src_bit=0, in_ready=1, out_valid=0, product=0, err=0, pass_cnt=0, err_cnt=0.
- Reset mid-SHIFT or mid-WAIT abandons the operation. Counters are unchanged from their reset value and no response is issued.
- Accept edge = E0. Column bits are shifted at E1..EW. dst is valid during the cycle after EW (+LAT cycles) and only then, because zeros follow.
- product is sampled at E(W+1+LAT). out_valid is high from that edge: 24 cycles after acceptance for W=23, LAT=0.
- out_ready may be low indefinitely; product and err must not change while waiting.
- Acceptance at the RESP→IDLE edge: in_ready rises the next cycle. The minimum issue interval is W+3+LAT cycles.

## Structure
- Package mul_cmp_pkg holds:
  - W and COLS=2W-1
  - functions col_height(k) and col_base(k)
  - the state enum
- Sub-module pp_column_gen: combinational, maps (a, b, t) to the 2W-1 src_bit vector. It is instantiated once.
- The FSM, t counter, sample/compare logic and counters stay in the top module.

## Test plan
- a=0, b=0 → product=0, err=0, pass_cnt=1, src_bit all-zero throughout.
- a=b=23'h7FFFFF → product=47'h3FFFFF000001, err=0, out_valid exactly 24 cycles after acceptance.
- a=1, b=23'h555555 → product=47'h555555. Check that every column receives its h(k) bits and the top column carries a[22]&b[22]=0.
- Back-pressure: hold out_ready=0 for 10 cycles in RESP → product and err stable, in_ready=0, src_bit=0, counters unchanged until acceptance.
- Reset at t=10 of SHIFT → all outputs take their reset values immediately. The next operand pair a=3, b=5 gives product=15 with no residue from the aborted run.
- Fault injection: force dst bit 0 inverted on a=2, b=2 → product=5, err=1, err_cnt=1. 65536 consecutive errors → err_cnt stays at 16'hFFFF.
